multicycle_control: RTL

- Control FSM that sequences the shared MIPS datapath over multiple cycles: one ALU and one unified instruction/data memory port, both time-shared.
- Supports the same ISA subset and the same 4-bit ALU_Control encoding as the single-cycle decoder:
  - ALU_Control: 0 add, 1 and, 2 or, 3 sll, 4 slt, 5 srl, 6 sub, 7 xor, 8 beq, 9 bne, 15 invalid.
- Memory accesses use a ready handshake with a bounded wait timeout.
- Sits between the instruction register (IR) and all datapath mux selects and write enables.

---
 rtl/multicycle_control_if.sv | 41 ++++
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// master : the controller (consumes IR fields/status, drives selects and enables)
// slave  : the datapath (drives IR fields/status, consumes selects and enables)
// Signals: opcode/funct (IR fields), bcond (branch condition), mem_ready
// (memory handshake), and all mux selects, write enables and status pulses.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       bcond;
  logic       mem_ready;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALU_Control;
  logic       RegDest;
  logic       RegWrite;
  logic       MemtoReg;
  logic       isJAL;
  logic       illegal;
  logic       mem_error;
  logic       retire;

  modport master (
    input  opcode, funct, bcond, mem_ready,
    output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
           ALUSrcB, ALU_Control, RegDest, RegWrite, MemtoReg, isJAL,
           illegal, mem_error, retire
  );

  modport slave (
    output opcode, funct, bcond, mem_ready,
    input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
           ALUSrcB, ALU_Control, RegDest, RegWrite, MemtoReg, isJAL,
           illegal, mem_error, retire
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences a shared ALU and a unified memory
// port through FETCH/DECODE/execute/writeback steps, with a ready handshake
// and bounded wait timeout on every memory access.
// Ports: clk, reset (sync, active-high), bus (multicycle_control_if.master).
module multicycle_control #(
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LB   = 6'h20, OP_LW   = 6'h23,
                         OP_SB    = 6'h28, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_XOR = 6'h26, FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_RWB, S_EXEC_I, S_IWB, S_BRANCH, S_JUMP, S_JR
  } state_t;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_a, alu_src_b;
    logic [3:0] alu_ctl;
    logic       reg_dest, reg_write, memto_reg, is_jal, illegal, mem_error, retire;
  } ctl_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall, timeout;
  logic              is_load, is_store, r_ok, r_shift, i_ok;
  logic [3:0]        r_alu, i_alu;
  ctl_t              ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= stall ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  assign timeout = !bus.mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    is_load  = (bus.opcode == OP_LW) || (bus.opcode == OP_LB);
    is_store = (bus.opcode == OP_SW) || (bus.opcode == OP_SB);
    r_ok = 1'b1; r_shift = 1'b0; r_alu = 4'd15;
    case (bus.funct)
      FN_ADD:  r_alu = 4'd0;
      FN_AND:  r_alu = 4'd1;
      FN_OR:   r_alu = 4'd2;
      FN_SLL:  begin r_alu = 4'd3; r_shift = 1'b1; end
      FN_SLT:  r_alu = 4'd4;
      FN_SRL:  begin r_alu = 4'd5; r_shift = 1'b1; end
      FN_SUB:  r_alu = 4'd6;
      FN_XOR:  r_alu = 4'd7;
      default: r_ok = 1'b0;
    endcase
    i_ok = 1'b1; i_alu = 4'd15;
    case (bus.opcode)
      OP_ADDI: i_alu = 4'd0;
      OP_ANDI: i_alu = 4'd1;
      OP_ORI:  i_alu = 4'd2;
      OP_SLTI: i_alu = 4'd4;
      OP_XORI: i_alu = 4'd7;
      default: i_ok = 1'b0;
    endcase
  end

  // Outputs are decoded from state plus same-cycle mem_ready/bcond, so they
  // cannot be registered without shifting the handshake by a cycle.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    ctl      = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_nx     = S_DECODE;
        end else if (timeout) begin
          ctl.mem_error = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        if (is_load || is_store)                                state_nx = S_MEMADDR;
        else if (bus.opcode == OP_RTYPE && bus.funct == FN_JR)  state_nx = S_JR;
        else if (bus.opcode == OP_RTYPE && r_ok)                state_nx = S_EXEC_R;
        else if (i_ok)                                          state_nx = S_EXEC_I;
        else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) state_nx = S_BRANCH;
        else if (bus.opcode == OP_J || bus.opcode == OP_JAL)   state_nx = S_JUMP;
        else begin
          ctl.illegal = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      S_MEMADDR: begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b10;
        state_nx      = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD, S_MEMWR: begin
        ctl.mem_read  = (state == S_MEMRD);
        ctl.mem_write = (state == S_MEMWR);
        ctl.iord      = 1'b1;
        if (bus.mem_ready) begin
          ctl.retire = (state == S_MEMWR);
          state_nx   = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (timeout) begin
          ctl.mem_error = 1'b1;
          state_nx      = S_FETCH;
        end else begin
          stall = 1'b1;
        end
      end
      S_MEMWB: begin
        ctl.reg_write = 1'b1;
        ctl.memto_reg = 1'b1;
        ctl.retire    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = r_shift ? 2'b10 : 2'b01;
        ctl.alu_ctl   = r_alu;
        state_nx      = S_RWB;
      end
      S_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dest  = 1'b1;
        ctl.retire    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b10;
        ctl.alu_ctl   = i_alu;
        state_nx      = S_IWB;
      end
      S_IWB: begin
        ctl.reg_write = 1'b1;
        ctl.retire    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_ctl   = (bus.opcode == OP_BNE) ? 4'd9 : 4'd8;
        ctl.pc_write  = bus.bcond;
        ctl.pc_source = 2'b01;
        ctl.retire    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
        ctl.reg_write = (bus.opcode == OP_JAL);
        ctl.is_jal    = (bus.opcode == OP_JAL);
        ctl.retire    = 1'b1;
        state_nx      = S_FETCH;
      end
      S_JR: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b11;
        ctl.retire    = 1'b1;
        state_nx      = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  assign {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
          bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_Control,
          bus.RegDest, bus.RegWrite, bus.MemtoReg, bus.isJAL, bus.illegal,
          bus.mem_error, bus.retire} = reset ? '0 : ctl;

endmodule
